// File: rtl/vector_rev_pipe.sv
// vector_rev_pipe: element/bit reversal transform in front of a 2-entry skid FIFO.
//
// The transform picked by `mode` is applied to `in_data` at acceptance, and the
// result is stored. A later change of `mode` therefore never alters a stored
// entry. The head entry drives `out_data` straight from a register. A second
// (skid) entry absorbs one extra accept while the output is stalled. `in_ready`
// is registered from the next occupancy, so it never depends combinationally on
// `out_ready`.
//
// Optional feature: define VECTOR_REV_PIPE_PARITY_EN to add `out_par`. It is the
// XOR of all bits of the stored result, and it travels with each entry.
module vector_rev_pipe #(
    parameter int WIDTH = 100,
    parameter int ELEM  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      xfer_cnt
`ifdef VECTOR_REV_PIPE_PARITY_EN
    ,
    output logic             out_par
`endif
);

    localparam int NELEM = WIDTH / ELEM;

    // Reject geometries the element-reversal indexing cannot describe.
    if (WIDTH < 2 || ELEM < 1 || (WIDTH % ELEM) != 0) begin : g_bad_geometry
        $error("vector_rev_pipe: WIDTH must be >= 2 and a multiple of ELEM");
    end

    // Transform select, applied to the vector as it is accepted.
    function automatic logic [WIDTH-1:0] vec_xform(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       m);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            2'b01: begin
                // Element order reversed, bits inside each element untouched.
                for (int k = 0; k < NELEM; k++) begin
                    for (int b = 0; b < ELEM; b++) begin
                        r[k*ELEM + b] = d[(NELEM-1-k)*ELEM + b];
                    end
                end
            end
            2'b10: begin
                // Bits reversed inside each element, element order kept.
                for (int k = 0; k < NELEM; k++) begin
                    for (int b = 0; b < ELEM; b++) begin
                        r[k*ELEM + b] = d[k*ELEM + (ELEM-1-b)];
                    end
                end
            end
            2'b11: begin
                for (int i = 0; i < WIDTH; i++) begin
                    r[i] = d[WIDTH-1-i];
                end
            end
            default: r = d;
        endcase
        return r;
    endfunction

    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             pop;
    logic             load_head;
    logic             load_skid;
    logic             shift_skid;
    logic [WIDTH-1:0] xf_data_p0;

    // ---- stage p0: accept handshake and transform of the incoming vector ----
    logic [WIDTH-1:0] head_data_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             in_ready_r;
    logic [15:0]      cnt_r;

    assign xf_data_p0 = vec_xform(in_data, mode);
    assign push       = in_valid & in_ready_r;
    assign pop        = out_valid & out_ready;

    // Next occupancy plus the routing of the new entry into head or skid.
    always_comb begin
        count_next = count;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case ({push, pop})
            2'b10: begin
                count_next = count + 2'd1;
                if (count == 2'd0) begin
                    load_head = 1'b1;
                end else begin
                    load_skid = 1'b1;
                end
            end
            2'b01: begin
                count_next = count - 2'd1;
                if (count == 2'd2) begin
                    shift_skid = 1'b1;
                end
            end
            2'b11: begin
                // Push only happens below occupancy 2, so this is occupancy 1:
                // the new entry replaces the departing head.
                load_head = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- stage p1: stored entries and control state ----
    // Occupancy, registered ready, and the output transfer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            in_ready_r <= 1'b0;
            cnt_r      <= 16'd0;
        end else begin
            count      <= count_next;
            in_ready_r <= (count_next < 2'd2);
            if (pop) begin
                cnt_r <= cnt_r + 16'd1;
            end
        end
    end

    // The head entry drives out_data and is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_data_p1 <= '0;
        end else if (load_head) begin
            head_data_p1 <= xf_data_p0;
        end else if (shift_skid) begin
            head_data_p1 <= skid_data_p1;
        end
    end

    // The skid entry is only read when occupancy says it is valid, so it has no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_p1 <= xf_data_p0;
        end
    end

`ifdef VECTOR_REV_PIPE_PARITY_EN
    logic head_par_p1;
    logic skid_par_p1;

    // Parity of the head entry, computed from the transformed vector at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_par_p1 <= 1'b0;
        end else if (load_head) begin
            head_par_p1 <= ^xf_data_p0;
        end else if (shift_skid) begin
            head_par_p1 <= skid_par_p1;
        end
    end

    // Parity of the skid entry, captured together with its data.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_par_p1 <= ^xf_data_p0;
        end
    end

    assign out_par = head_par_p1;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = (count != 2'd0);
    assign out_data  = head_data_p1;
    assign xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_vector_rev_pipe.sv
// Directed bench for vector_rev_pipe.
// It uses one WIDTH=8/ELEM=4 instance and one WIDTH=100/ELEM=1 instance.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_vector_rev_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        v8 = 1'b0, rdy8, ov8, ord8 = 1'b0;
    logic [7:0]  d8 = '0, od8;
    logic [1:0]  m8 = '0;
    logic [15:0] cnt8;

    logic        v100 = 1'b0, rdy100, ov100, ord100 = 1'b0;
    logic [99:0] d100 = '0, od100;
    logic [1:0]  m100 = '0;
    logic [15:0] cnt100;

`ifdef VECTOR_REV_PIPE_PARITY_EN
    logic op8, op100;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vector_rev_pipe #(.WIDTH(8), .ELEM(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8), .mode(m8),
        .out_valid(ov8), .out_ready(ord8), .out_data(od8), .xfer_cnt(cnt8)
`ifdef VECTOR_REV_PIPE_PARITY_EN
        , .out_par(op8)
`endif
    );

    vector_rev_pipe #(.WIDTH(100), .ELEM(1)) dut100 (
        .clk(clk), .rst(rst), .in_valid(v100), .in_ready(rdy100), .in_data(d100), .mode(m100),
        .out_valid(ov100), .out_ready(ord100), .out_data(od100), .xfer_cnt(cnt100)
`ifdef VECTOR_REV_PIPE_PARITY_EN
        , .out_par(op100)
`endif
    );

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; v8 = 1'b0; ord8 = 1'b0; v100 = 1'b0; ord100 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; v8 = 1'b1; d8 = 8'hAA; ord8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov8); end
        n_checks++; if (od8 !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", od8); end
        n_checks++; if (cnt8 !== 16'd0) begin n_fail++; $display("FAIL reset_xfer_cnt got %0d want 0", cnt8); end
        n_checks++; if (rdy8 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", rdy8); end
        v8 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", rdy8); end
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got %b want 0", ov8); end
    endtask

    task automatic test_modes();
        logic [7:0] exp_tab [4];
        exp_tab[0] = 8'h1E; exp_tab[1] = 8'hE1; exp_tab[2] = 8'h87; exp_tab[3] = 8'h78;
        ord8 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            v8 = 1'b1; d8 = 8'h1E; m8 = 2'(m);
            @(negedge clk);
            n_checks++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL mode%0d_valid got %b want 1", m, ov8); end
            n_checks++; if (od8 !== exp_tab[m]) begin n_fail++; $display("FAIL mode%0d_data got %h want %h", m, od8, exp_tab[m]); end
`ifdef VECTOR_REV_PIPE_PARITY_EN
            n_checks++; if (op8 !== 1'b0) begin n_fail++; $display("FAIL mode%0d_par got %b want 0", m, op8); end
`endif
        end
        v8 = 1'b0;
        @(negedge clk);
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL modes_drain_valid got %b want 0", ov8); end
        n_checks++; if (cnt8 !== 16'd4) begin n_fail++; $display("FAIL modes_xfer_cnt got %0d want 4", cnt8); end
        ord8 = 1'b0;
    endtask

    task automatic test_full_reverse();
        logic [99:0] e;
        ord100 = 1'b1; m100 = 2'b11; v100 = 1'b1; d100 = 100'd1024;
        @(negedge clk);
        e = '0; e[89] = 1'b1;
        n_checks++; if (ov100 !== 1'b1) begin n_fail++; $display("FAIL fullrev_valid got %b want 1", ov100); end
        n_checks++; if (od100 !== e) begin n_fail++; $display("FAIL fullrev_1024 got %h want %h", od100, e); end
        d100 = 100'd255;
        @(negedge clk);
        e = '0; e[99:92] = 8'hFF;
        n_checks++; if (od100 !== e) begin n_fail++; $display("FAIL fullrev_255 got %h want %h", od100, e); end
        v100 = 1'b0;
        @(negedge clk);
        n_checks++; if (cnt100 !== 16'd2) begin n_fail++; $display("FAIL fullrev_xfer_cnt got %0d want 2", cnt100); end
        ord100 = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        m8 = 2'b00; ord8 = 1'b0; v8 = 1'b1; d8 = 8'd1;
        @(negedge clk);
        d8 = 8'd2;
        @(negedge clk);
        d8 = 8'd3;
        @(negedge clk);
        n_checks++; if (rdy8 !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", rdy8); end
        n_checks++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid got %b want 1", ov8); end
        n_checks++; if (od8 !== 8'd1) begin n_fail++; $display("FAIL bp_hold_data got %h want 01", od8); end
        @(negedge clk);
        n_checks++; if (od8 !== 8'd1) begin n_fail++; $display("FAIL bp_still_held got %h want 01", od8); end
        ord8 = 1'b1;
        @(negedge clk);
        n_checks++; if (od8 !== 8'd2) begin n_fail++; $display("FAIL bp_out2 got %h want 02", od8); end
        @(negedge clk);
        n_checks++; if (od8 !== 8'd3) begin n_fail++; $display("FAIL bp_out3 got %h want 03", od8); end
        v8 = 1'b0;
        @(negedge clk);
        n_checks++; if (cnt8 !== 16'd3) begin n_fail++; $display("FAIL bp_xfer_cnt got %0d want 3", cnt8); end
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_empty_valid got %b want 0", ov8); end
        ord8 = 1'b0;
    endtask

    task automatic test_stored_mode();
        apply_reset();
        ord8 = 1'b0; v8 = 1'b1; d8 = 8'h1E; m8 = 2'b11;
        @(negedge clk);
        v8 = 1'b0; m8 = 2'b00;
        @(negedge clk);
        n_checks++; if (od8 !== 8'h78) begin n_fail++; $display("FAIL stored_mode got %h want 78", od8); end
        ord8 = 1'b1;
        @(negedge clk);
        ord8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        m8 = 2'b00; ord8 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            v8 = 1'b1; d8 = 8'(i);
            @(negedge clk);
            n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d got %b want 1", i, rdy8); end
            n_checks++; if (od8 !== 8'(i)) begin n_fail++; $display("FAIL stream_data%0d got %h want %h", i, od8, 8'(i)); end
        end
        v8 = 1'b0;
        @(negedge clk);
        n_checks++; if (cnt8 !== 16'd10) begin n_fail++; $display("FAIL stream_xfer_cnt got %0d want 10", cnt8); end
        ord8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ord8 = 1'b0; m8 = 2'b00; v8 = 1'b1; d8 = 8'h11;
        @(negedge clk);
        d8 = 8'h22;
        @(negedge clk);
        v8 = 1'b0; ord8 = 1'b1; rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", ov8); end
        n_checks++; if (cnt8 !== 16'd0) begin n_fail++; $display("FAIL midrst_xfer_cnt got %0d want 0", cnt8); end
        n_checks++; if (rdy8 !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b want 0", rdy8); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after got %b want 1", rdy8); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL midrst_stale%0d got %b want 0", i, ov8); end
            @(negedge clk);
        end
        n_checks++; if (cnt8 !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt_after got %0d want 0", cnt8); end
        ord8 = 1'b0;
    endtask

`ifdef VECTOR_REV_PIPE_PARITY_EN
    task automatic test_parity();
        apply_reset();
        ord8 = 1'b1; v8 = 1'b1; d8 = 8'h07; m8 = 2'b01;
        @(negedge clk);
        n_checks++; if (op8 !== 1'b1) begin n_fail++; $display("FAIL parity_07 got %b want 1", op8); end
        d8 = 8'h1E; m8 = 2'b10;
        @(negedge clk);
        n_checks++; if (op8 !== 1'b0) begin n_fail++; $display("FAIL parity_1E got %b want 0", op8); end
        v8 = 1'b0;
        @(negedge clk);
        ord8 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_modes();
        test_full_reverse();
        test_backpressure();
        test_stored_mode();
        test_back_to_back();
        test_reset_mid();
`ifdef VECTOR_REV_PIPE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
